// File: rtl/fpsu_alt_pkg.sv
// fpsu_alt_pkg: shared widths, data type and source ids for the FPSU alternate-data injector
package fpsu_alt_pkg;
  localparam int ALT_WIDTH = 68;
  localparam int ALT_DEPTH = 4;
  typedef logic [ALT_WIDTH-1:0] alt_data_t;
  typedef enum logic {ALT_SRC0, ALT_SRC1} alt_src_e;
endpackage

// File: rtl/fpsu_alt_fifo.sv
// fpsu_alt_fifo: per-source sync FIFO with async reset.
// Ports: clk, rst (async, active-high), i_push/i_data write, i_pop read,
//        o_head (current head entry), o_count (occupancy), o_full, o_empty.
module fpsu_alt_fifo
  import fpsu_alt_pkg::*;
#(
  parameter int WIDTH = ALT_WIDTH,
  parameter int DEPTH = ALT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/fpsu_alt_inject.sv
// fpsu_alt_inject: buffers two producer streams and injects them onto FUF6 via ALT_INP/ALTDATA.
// Ports: clk, rst (async, active-high); src0/src1 valid/ready/data inputs;
//        slot_free (FPSU port-0 leaves FUF6 free two cycles later);
//        ALT_INP one-hot select, ALTDATA0/ALTDATA1 registered injection data.
// Option: define FPSU_ALT_BYPASS_EN to let a granted source with an empty FIFO
//         load ALTDATAx straight from its input (one cycle less latency).
module fpsu_alt_inject
  import fpsu_alt_pkg::*;
#(
  parameter int WIDTH = ALT_WIDTH,
  parameter int DEPTH = ALT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src0_data,
  input  logic             src0_valid,
  output logic             src0_ready,
  input  logic [WIDTH-1:0] src1_data,
  input  logic             src1_valid,
  output logic             src1_ready,
  input  logic             slot_free,
  output logic [1:0]       ALT_INP,
  output logic [WIDTH-1:0] ALTDATA0,
  output logic [WIDTH-1:0] ALTDATA1
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [1:0]       r_alt_inp;
  logic [WIDTH-1:0] r_altdata0, r_altdata1;
  alt_src_e         r_rr;
  logic [WIDTH-1:0] w_head0, w_head1, w_d0, w_d1;
  logic [CW-1:0]    w_cnt0, w_cnt1;
  logic             w_full0, w_full1, w_empty0, w_empty1;
  logic             w_byp0, w_byp1, w_elig0, w_elig1, w_g0, w_g1;
  logic             w_push0, w_push1, w_pop0, w_pop1;
  assign src0_ready = ~w_full0 & ~rst;
  assign src1_ready = ~w_full1 & ~rst;
`ifdef FPSU_ALT_BYPASS_EN
  assign w_byp0 = w_empty0 & src0_valid;
  assign w_byp1 = w_empty1 & src1_valid;
`else
  assign w_byp0 = 1'b0;
  assign w_byp1 = 1'b0;
`endif
  // a source that injected last cycle sits out one cycle so ALTDATAx holds through the FUF6 drive
  assign w_elig0 = (~w_empty0 | w_byp0) & ~r_alt_inp[0];
  assign w_elig1 = (~w_empty1 | w_byp1) & ~r_alt_inp[1];
  assign w_g0    = slot_free & w_elig0 & (~w_elig1 | r_rr == ALT_SRC0);
  assign w_g1    = slot_free & w_elig1 & (~w_elig0 | r_rr == ALT_SRC1);
  assign w_push0 = src0_valid & src0_ready & ~(w_g0 & w_byp0);
  assign w_push1 = src1_valid & src1_ready & ~(w_g1 & w_byp1);
  assign w_pop0  = w_g0 & (w_cnt0 != '0);
  assign w_pop1  = w_g1 & (w_cnt1 != '0);
  assign w_d0    = w_byp0 ? src0_data : w_head0;
  assign w_d1    = w_byp1 ? src1_data : w_head1;
  assign ALT_INP  = r_alt_inp;
  assign ALTDATA0 = r_altdata0;
  assign ALTDATA1 = r_altdata1;
  fpsu_alt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .i_push(w_push0), .i_data(src0_data), .i_pop(w_pop0),
    .o_head(w_head0), .o_count(w_cnt0), .o_full(w_full0), .o_empty(w_empty0)
  );
  fpsu_alt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .i_push(w_push1), .i_data(src1_data), .i_pop(w_pop1),
    .o_head(w_head1), .o_count(w_cnt1), .o_full(w_full1), .o_empty(w_empty1)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_alt_inp  <= 2'b00;
      r_altdata0 <= '0;
      r_altdata1 <= '0;
      r_rr       <= ALT_SRC0;
    end else begin
      r_alt_inp <= {w_g1, w_g0};
      if (w_g0) r_altdata0 <= w_d0;
      if (w_g1) r_altdata1 <= w_d1;
      if (w_g0 | w_g1) r_rr <= w_g0 ? ALT_SRC1 : ALT_SRC0;
    end
endmodule

// File: tb/tb_fpsu_alt_inject.sv
// tb_fpsu_alt_inject: scoreboard bench for fpsu_alt_inject (directed cases plus random slot_free traffic)
module tb_fpsu_alt_inject;
  import fpsu_alt_pkg::*;
  logic clk = 1'b0;
  logic rst, src0_valid, src1_valid, src0_ready, src1_ready, slot_free;
  alt_data_t src0_data, src1_data, ALTDATA0, ALTDATA1;
  logic [1:0] ALT_INP;
  int n_chk = 0, n_err = 0, sent = 0;
  alt_data_t q0[$], q1[$];
  alt_data_t hold0, hold1, exp_v;
  logic hold_v0 = 0, hold_v1 = 0, prev_sf = 0, acc0 = 0, acc1 = 0;
  logic [1:0] prev_alt = 0;
  always #5 clk = ~clk;
  fpsu_alt_inject dut (
    .clk(clk), .rst(rst),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .slot_free(slot_free), .ALT_INP(ALT_INP), .ALTDATA0(ALTDATA0), .ALTDATA1(ALTDATA1)
  );
  task automatic chk(input string tag, input alt_data_t got, input alt_data_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    src0_valid = 0;
    src1_valid = 0;
  endtask
  // monitor: scoreboard push on handshake, pop/compare on injection, protocol rules
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_alt_inp", ALT_INP, 0);
      chk("rst_altdata0", ALTDATA0, 0);
      chk("rst_altdata1", ALTDATA1, 0);
      chk("rst_ready0", src0_ready, 0);
      chk("rst_ready1", src1_ready, 0);
      q0.delete();
      q1.delete();
      hold_v0 = 0;
      hold_v1 = 0;
      acc0 = 0;
      acc1 = 0;
      prev_alt = 0;
    end else begin
      chk("alt_not_11", ALT_INP == 2'b11, 0);
      if (ALT_INP != 0) chk("grant_needs_slot", prev_sf, 1);
      if (ALT_INP[0]) begin
        chk("alt0_spacing", prev_alt[0], 0);
        chk("sb0_has_entry", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          exp_v = q0.pop_front();
          chk("altdata0", ALTDATA0, exp_v);
        end
        hold0 = ALTDATA0;
        hold_v0 = 1;
      end else if (hold_v0) begin
        chk("altdata0_hold", ALTDATA0, hold0);
        hold_v0 = 0;
      end
      if (ALT_INP[1]) begin
        chk("alt1_spacing", prev_alt[1], 0);
        chk("sb1_has_entry", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          exp_v = q1.pop_front();
          chk("altdata1", ALTDATA1, exp_v);
        end
        hold1 = ALTDATA1;
        hold_v1 = 1;
      end else if (hold_v1) begin
        chk("altdata1_hold", ALTDATA1, hold1);
        hold_v1 = 0;
      end
      acc0 = src0_valid & src0_ready;
      acc1 = src1_valid & src1_ready;
      if (acc0) q0.push_back(src0_data);
      if (acc1) q1.push_back(src1_data);
      prev_alt = ALT_INP;
    end
    prev_sf = slot_free;
  end
  initial begin
    rst = 0;
    idle();
    slot_free = 0;
    src0_data = '0;
    src1_data = '0;
    #2 rst = 1;
    repeat (2) cyc();
    rst = 0;
    // reset mid-stream: one injection in flight, three entries queued
    for (int i = 0; i < 4; i++) begin
      cyc();
      src0_valid = 1;
      src0_data = alt_data_t'(68'h0AA00 + i);
    end
    cyc();
    idle();
    slot_free = 1;
    cyc();
    slot_free = 0;
    cyc();
    rst = 1;
    @(negedge clk);
    cyc();
    cyc();
    rst = 0;
    @(negedge clk);
    chk("ready0_after_rst", src0_ready, 1);
    chk("ready1_after_rst", src1_ready, 1);
    slot_free = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("no_inject_after_rst", ALT_INP, 0);
    end
    slot_free = 0;
    // contention: two entries each, pointer starts at src0
    for (int i = 0; i < 2; i++) begin
      cyc();
      src0_valid = 1;
      src0_data = alt_data_t'(68'h100 + i);
      src1_valid = 1;
      src1_data = alt_data_t'(68'h200 + i);
    end
    cyc();
    idle();
    slot_free = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("contend_alt", ALT_INP, (k % 2) ? 2'b10 : 2'b01);
    end
    slot_free = 0;
    repeat (2) cyc();
    // single-item latency
    src0_valid = 1;
    src0_data = 68'h0_1234_5678_9ABC_DEF0;
    slot_free = 1;
    @(negedge clk);
    chk("lat_n", ALT_INP, 0);
    cyc();
    idle();
    @(negedge clk);
`ifdef FPSU_ALT_BYPASS_EN
    chk("lat_n1", ALT_INP, 2'b01);
    chk("lat_n1_data", ALTDATA0, 68'h0_1234_5678_9ABC_DEF0);
`else
    chk("lat_n1", ALT_INP, 2'b00);
`endif
    cyc();
    @(negedge clk);
`ifdef FPSU_ALT_BYPASS_EN
    chk("lat_n2", ALT_INP, 2'b00);
`else
    chk("lat_n2", ALT_INP, 2'b01);
`endif
    chk("lat_n2_data", ALTDATA0, 68'h0_1234_5678_9ABC_DEF0);
    cyc();
    @(negedge clk);
    chk("lat_n3_data", ALTDATA0, 68'h0_1234_5678_9ABC_DEF0);
    slot_free = 0;
    // same-source spacing
    for (int i = 0; i < 4; i++) begin
      cyc();
      src0_valid = 1;
      src0_data = alt_data_t'(68'h400 + i);
    end
    cyc();
    idle();
    slot_free = 1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      @(negedge clk);
      chk("spacing_alt", ALT_INP, (k % 2) ? 2'b00 : 2'b01);
    end
    slot_free = 0;
    cyc();
    // full / backpressure: fifth item held until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      cyc();
      src0_valid = 1;
      src0_data = alt_data_t'(68'h500 + i);
    end
    cyc();
    src0_data = alt_data_t'(68'h5FF);
    @(negedge clk);
    chk("full_ready", src0_ready, 0);
    cyc();
    slot_free = 1;
    @(negedge clk);
    chk("full_pop_ready", src0_ready, 0);
    cyc();
    slot_free = 0;
    @(negedge clk);
    chk("ready_after_pop", src0_ready, 1);
    cyc();
    idle();
    slot_free = 1;
    repeat (12) cyc();
    slot_free = 0;
    @(negedge clk);
    chk("drain0_bp", q0.size(), 0);
    // random traffic with sparse free slots
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      cyc();
      if (acc0) sent++;
      if (acc1) sent++;
      if (!src0_valid || acc0) begin
        src0_valid = ($urandom_range(0, 1) == 1) && sent < 1000;
        src0_data = alt_data_t'({$urandom(), $urandom(), $urandom()});
      end
      if (!src1_valid || acc1) begin
        src1_valid = ($urandom_range(0, 1) == 1) && sent < 1000;
        src1_data = alt_data_t'({$urandom(), $urandom(), $urandom()});
      end
      slot_free = $urandom_range(0, 9) < 3;
    end
    idle();
    slot_free = 1;
    repeat (24) cyc();
    @(negedge clk);
    chk("random_sent", sent >= 1000, 1);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
